// File: rtl/mainbus_pkg.sv
// Shared definitions for the 8-bit main bus register-load path (transmit and receive sides).
package mainbus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   localparam int MAINBUS_W  = 8;
   localparam int ONEHOT_MAX = 32;

   // One-hot of idx wrapped modulo n; callers truncate to their own strobe count.
   function automatic logic [ONEHOT_MAX-1:0] onehot_wrap(input int unsigned idx,
                                                         input int unsigned n);
      return ONEHOT_MAX'(1) << (idx % n);
   endfunction

endpackage

// File: rtl/mainbus_onehot_dec.sv
// Destination index to one-hot reg_load decoder with enable; shared with the receive-side register file.
module mainbus_onehot_dec
   import mainbus_pkg::*;
#(
   parameter int IDX_W = 2,
   parameter int NDEST = 4
) (
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_en,
   output logic [NDEST-1:0] o_sel
);

   assign o_sel = i_en ? NDEST'(onehot_wrap(32'(i_idx), NDEST)) : '0;

endmodule

// File: rtl/mainbus_word_xmit.sv
// Main bus word transmitter: serialises a word LSB-first with a setup cycle before each reg_load strobe.
// Optional MAINBUS_XMIT_PARITY_EN adds a registered even-parity output bus_par.
module mainbus_word_xmit
   import mainbus_pkg::*;
#(
   parameter int DATA_W = MAINBUS_W,
   parameter int BEATS  = 2,
   parameter int NDEST  = 4,
   parameter int IDX_W  = 2
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BEATS*DATA_W-1:0] in_word,
   input  logic [IDX_W-1:0]        in_dest,
   input  logic                    bus_grant,
   output logic [DATA_W-1:0]       bus_out,
   output logic                    bus_oe,
   output logic [NDEST-1:0]        ld_sel,
   output logic                    done
`ifdef MAINBUS_XMIT_PARITY_EN
  ,output logic                    bus_par
`endif
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_t                  r_state;
   logic [BEATS*DATA_W-1:0] r_word;
   logic [IDX_W-1:0]        r_dest;
   logic [BEAT_W-1:0]       r_beat;
   logic [DATA_W-1:0]       r_bus_out;
   logic                    r_bus_oe;
   logic [NDEST-1:0]        r_ld_sel;
   logic                    r_done;

   logic                    w_last;
   logic [BEAT_W-1:0]       w_sel_beat;
   logic [DATA_W-1:0]       w_bus_next;
   logic                    w_bus_load;
   logic [IDX_W-1:0]        w_dest_idx;
   logic                    w_dec_en;
   logic [NDEST-1:0]        w_ld_next;

   // bus_oe doubles as the "granted setup" flag: grant is sampled at the edge that opens a setup cycle.
   assign w_last     = (r_beat == BEAT_W'(BEATS - 1));
   assign w_sel_beat = (r_state == STROBE && !w_last) ? r_beat + BEAT_W'(1) : r_beat;
   assign w_bus_next = (r_state == IDLE) ? in_word[DATA_W-1:0]
                                         : r_word[int'(w_sel_beat)*DATA_W +: DATA_W];
   assign w_bus_load = bus_grant && ((r_state == IDLE   && in_valid)  ||
                                     (r_state == SETUP  && !r_bus_oe) ||
                                     (r_state == STROBE && !w_last));
   assign w_dest_idx = IDX_W'((32'(r_dest) + 32'(r_beat)) % NDEST);
   assign w_dec_en   = (r_state == SETUP) && r_bus_oe;

   mainbus_onehot_dec #(
      .IDX_W (IDX_W),
      .NDEST (NDEST)
   ) u_dec (
      .i_idx (w_dest_idx),
      .i_en  (w_dec_en),
      .o_sel (w_ld_next)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state   <= IDLE;
         r_word    <= '0;
         r_dest    <= '0;
         r_beat    <= '0;
         r_bus_out <= '0;
         r_bus_oe  <= 1'b0;
         r_ld_sel  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_ld_sel <= w_ld_next;
         r_done   <= 1'b0;
         if (w_bus_load) r_bus_out <= w_bus_next;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_word   <= in_word;
                  r_dest   <= in_dest;
                  r_beat   <= '0;
                  r_bus_oe <= bus_grant;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               if (r_bus_oe) begin
                  r_state <= STROBE;
                  r_done  <= w_last;
               end else begin
                  r_bus_oe <= bus_grant;
               end
            end
            STROBE: begin
               if (w_last) begin
                  r_bus_oe <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  r_beat   <= r_beat + BEAT_W'(1);
                  r_bus_oe <= bus_grant;
                  r_state  <= SETUP;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MAINBUS_XMIT_PARITY_EN
   logic r_bus_par;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_bus_par <= 1'b0;
      end else if (w_bus_load) begin
         r_bus_par <= ^w_bus_next;
      end
   end

   assign bus_par = r_bus_par;
`endif

   // NOTE: in_ready is decoded straight from state so a word is accepted in the very first IDLE cycle.
   assign in_ready = (r_state == IDLE);
   assign bus_out  = r_bus_out;
   assign bus_oe   = r_bus_oe;
   assign ld_sel   = r_ld_sel;
   assign done     = r_done;

endmodule

// File: tb/tb_mainbus_word_xmit.sv
// Self-checking bench for mainbus_word_xmit: directed scenarios then random traffic against a cycle model.
module tb_mainbus_word_xmit;

   localparam int DATA_W = 8;
   localparam int BEATS  = 2;
   localparam int NDEST  = 4;
   localparam int IDX_W  = 2;

   logic                    clk;
   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic [BEATS*DATA_W-1:0] in_word;
   logic [IDX_W-1:0]        in_dest;
   logic                    bus_grant;
   logic [DATA_W-1:0]       bus_out;
   logic                    bus_oe;
   logic [NDEST-1:0]        ld_sel;
   logic                    done;
`ifdef MAINBUS_XMIT_PARITY_EN
   logic                    bus_par;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: one transfer = per beat, a granted setup cycle then a strobe cycle.
   bit                    m_busy;
   bit                    m_setup_ok;
   bit                    m_strobe;
   logic [BEATS*DATA_W-1:0] m_word;
   int                    m_dest;
   int                    m_k;
   logic [DATA_W-1:0]     m_out;
   logic [DATA_W-1:0]     exp_rx [NDEST];
   logic [DATA_W-1:0]     rx     [NDEST];
   logic [DATA_W-1:0]     q_strobes [$];

   mainbus_word_xmit #(
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .NDEST  (NDEST),
      .IDX_W  (IDX_W)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_dest   (in_dest),
      .bus_grant (bus_grant),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .ld_sel    (ld_sel),
      .done      (done)
`ifdef MAINBUS_XMIT_PARITY_EN
     ,.bus_par   (bus_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] get_byte(input logic [BEATS*DATA_W-1:0] w, input int k);
      return w[k*DATA_W +: DATA_W];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 1'b0;
      m_setup_ok = 1'b0;
      m_strobe   = 1'b0;
      m_word     = '0;
      m_dest     = 0;
      m_k        = 0;
      m_out      = '0;
   endtask

   task automatic model_edge();
      if (clear) begin
         model_reset();
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy     = 1'b1;
            m_word     = in_word;
            m_dest     = int'(in_dest);
            m_k        = 0;
            m_strobe   = 1'b0;
            m_setup_ok = bus_grant;
            if (bus_grant) m_out = get_byte(in_word, 0);
         end
      end else if (m_strobe) begin
         m_strobe = 1'b0;
         if (m_k == BEATS - 1) begin
            m_busy     = 1'b0;
            m_setup_ok = 1'b0;
         end else begin
            m_k++;
            m_setup_ok = bus_grant;
            if (bus_grant) m_out = get_byte(m_word, m_k);
         end
      end else if (m_setup_ok) begin
         m_setup_ok = 1'b0;
         m_strobe   = 1'b1;
      end else begin
         m_setup_ok = bus_grant;
         if (bus_grant) m_out = get_byte(m_word, m_k);
      end
   endtask

   task automatic compare_all();
      logic [31:0] e_ld;
      int          cnt;
      e_ld = m_strobe ? (32'(1) << ((m_dest + m_k) % NDEST)) : 32'(0);
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("bus_oe",   32'(bus_oe),   32'(m_setup_ok || m_strobe));
      check("ld_sel",   32'(ld_sel),   e_ld);
      check("done",     32'(done),     32'(m_strobe && m_k == BEATS - 1));
      check("bus_out",  32'(bus_out),  32'(m_out));
`ifdef MAINBUS_XMIT_PARITY_EN
      check("bus_par",  32'(bus_par),  32'(^m_out));
`endif
      cnt = $countones(ld_sel);
      check("ld_onehot", 32'(cnt > 1 || (cnt == 1 && !bus_oe)), 32'(0));
      if (m_strobe) exp_rx[(m_dest + m_k) % NDEST] = m_out;
      for (int i = 0; i < NDEST; i++) if (ld_sel[i]) rx[i] = bus_out;
      if (ld_sel != '0) q_strobes.push_back(bus_out);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int lat;
      int low_cnt;

      clear     = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      in_dest   = '0;
      bus_grant = 1'b0;
      model_reset();
      for (int i = 0; i < NDEST; i++) begin
         rx[i]     = '0;
         exp_rx[i] = '0;
      end
      #1;
      compare_all();
      cycle();
      cycle();
      clear = 1'b0;

      // Reset mid-transfer: clear lands during the first strobe of 0xBEEF.
      in_valid = 1'b1; in_word = 16'hBEEF; in_dest = 2'd0; bus_grant = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      check("t1_strobe_before_clear", 32'(ld_sel), 32'h1);
      clear = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("t1_clear_oe", 32'(bus_oe), 32'(0));
      check("t1_clear_ld", 32'(ld_sel), 32'(0));
      check("t1_clear_ready", 32'(in_ready), 32'(1));
      cycle();
      clear = 1'b0;
      cycle();

      // Basic send 0x7B01 to register 1.
      in_valid = 1'b1; in_word = 16'h7B01; in_dest = 2'd1; bus_grant = 1'b1;
      cycle();
      in_valid = 1'b0;
      check("t2_c1_out", 32'(bus_out), 32'h01);
      check("t2_c1_oe",  32'(bus_oe),  32'h1);
      check("t2_c1_ld",  32'(ld_sel),  32'h0);
`ifdef MAINBUS_XMIT_PARITY_EN
      check("t6_par_01", 32'(bus_par), 32'h1);
`endif
      cycle();
      check("t2_c2_ld", 32'(ld_sel), 32'h2);
      cycle();
      check("t2_c3_out", 32'(bus_out), 32'h7B);
      check("t2_c3_ld",  32'(ld_sel),  32'h0);
      cycle();
      check("t2_c4_ld",   32'(ld_sel), 32'h4);
      check("t2_c4_done", 32'(done),   32'h1);
      check("t2_c4_out",  32'(bus_out), 32'h7B);
`ifdef MAINBUS_XMIT_PARITY_EN
      check("t6_par_7b", 32'(bus_par), 32'h0);
`endif
      cycle();
      check("t2_rx1", 32'(rx[1]), 32'h01);
      check("t2_rx2", 32'(rx[2]), 32'h7B);

      // Destination wrap: register 3 then register 0.
      in_valid = 1'b1; in_word = 16'hA55A; in_dest = 2'd3;
      cycle();
      in_valid = 1'b0;
      cycle();
      check("t3_ld_a", 32'(ld_sel), 32'h8);
      check("t3_out_a", 32'(bus_out), 32'h5A);
      cycle();
      cycle();
      check("t3_ld_b", 32'(ld_sel), 32'h1);
      check("t3_out_b", 32'(bus_out), 32'hA5);
      cycle();

      // Grant stall for 5 cycles ahead of the second beat.
      in_valid = 1'b1; in_word = 16'hC3D2; in_dest = 2'd2; bus_grant = 1'b1;
      cycle();
      lat = 1;
      in_valid = 1'b0;
      cycle();
      lat++;
      bus_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         lat++;
         check("t4_stall_oe", 32'(bus_oe), 32'h0);
         check("t4_stall_ld", 32'(ld_sel), 32'h0);
      end
      bus_grant = 1'b1;
      while (!done && lat < 20) begin
         cycle();
         lat++;
      end
      check("t4_latency", 32'(lat), 32'd9);
      cycle();

      // Back-to-back words with in_valid held.
      q_strobes.delete();
      low_cnt = 0;
      in_valid = 1'b1; in_word = 16'h1234; in_dest = 2'd0;
      cycle();
      in_word = 16'h5678;
      if (!in_ready) low_cnt++;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (!in_ready) low_cnt++;
      end
      in_valid = 1'b0;
      cycle();
      if (!in_ready) low_cnt++;
      check("t5_ready_low", 32'(low_cnt), 32'd8);
      check("t5_nstrobes", 32'(q_strobes.size()), 32'd4);
      if (q_strobes.size() == 4) begin
         check("t5_s0", 32'(q_strobes[0]), 32'h34);
         check("t5_s1", 32'(q_strobes[1]), 32'h12);
         check("t5_s2", 32'(q_strobes[2]), 32'h78);
         check("t5_s3", 32'(q_strobes[3]), 32'h56);
      end

      // Random traffic with intermittent grant.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_word   = 16'($urandom);
         in_dest   = 2'($urandom_range(0, NDEST - 1));
         bus_grant = ($urandom_range(0, 9) < 7);
         cycle();
      end
      in_valid  = 1'b0;
      bus_grant = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      for (int i = 0; i < NDEST; i++) check("rx_final", 32'(rx[i]), 32'(exp_rx[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
